// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state, owner and width definitions for the memory arbiter
package mem_arbiter_pkg;
  localparam int LINE_BEATS_DEF = 4;
  localparam int BEAT_W = 64;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~32'h1f;
  typedef enum logic [2:0] {IDLE, I_READ, D_READ, D_WRITE, DONE} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side and memory-side bus bundle; master = arbiter, slave = caches/memory
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;
  logic              icache_pmem_read;
  logic [ADDR_W-1:0] icache_pmem_address;
  logic [LINE_W-1:0] icache_pmem_rdata;
  logic              icache_pmem_resp;
  logic              dcache_pmem_read;
  logic              dcache_pmem_write;
  logic [ADDR_W-1:0] dcache_pmem_address;
  logic [LINE_W-1:0] dcache_pmem_wdata;
  logic [LINE_W-1:0] dcache_pmem_rdata;
  logic              dcache_pmem_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [BEAT_W-1:0] mem_burst_o;
  logic [BEAT_W-1:0] mem_burst_i;
  logic              mem_resp;
  modport master (
    input  icache_pmem_read, icache_pmem_address,
    input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    input  mem_burst_i, mem_resp,
    output icache_pmem_rdata, icache_pmem_resp, dcache_pmem_rdata, dcache_pmem_resp,
    output mem_read, mem_write, mem_address, mem_burst_o
  );
  modport slave (
    output icache_pmem_read, icache_pmem_address,
    output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    output mem_burst_i, mem_resp,
    input  icache_pmem_rdata, icache_pmem_resp, dcache_pmem_rdata, dcache_pmem_resp,
    input  mem_read, mem_write, mem_address, mem_burst_o
  );
endinterface

// File: rtl/line_adapter.sv
// line_adapter: splits a cache line into memory beats and assembles returned beats into a line
module line_adapter
  import mem_arbiter_pkg::*;
#(
  parameter int LINE_BEATS = LINE_BEATS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active,
  input  logic              wr,
  input  logic              resp,
  input  logic [LINE_W-1:0] wdata,
  input  logic [BEAT_W-1:0] burst_i,
  output logic [BEAT_W-1:0] burst_o,
  output logic [LINE_W-1:0] line_next,
  output logic              last
);
  localparam int CW = LINE_BEATS > 1 ? $clog2(LINE_BEATS) : 1;
  logic [CW-1:0] cnt;
  logic [LINE_W-1:0] acc;
  assign last = active && resp && cnt == CW'(LINE_BEATS - 1);
  assign burst_o = wr ? wdata[BEAT_W*int'(cnt) +: BEAT_W] : '0;
  // merge the beat on the bus into the partially assembled line
  always_comb begin
    line_next = acc;
    line_next[BEAT_W*int'(cnt) +: BEAT_W] = burst_i;
  end
  // beat counter advances only on accepted beats and restarts whenever no burst is running
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      acc <= '0;
    end else if (!active) cnt <= '0;
    else if (resp) begin
      cnt <= last ? '0 : cnt + 1'b1;
      acc <= line_next;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: icache/dcache to single-port burst memory arbiter; ARB_ROUND_ROBIN_EN selects round-robin grant
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LINE_BEATS = LINE_BEATS_DEF
) (
  input logic clk,
  input logic reset,
  mem_arbiter_if.master bus
);
  state_t state;
  logic dreq, ireq, grant_d, busy, last;
  logic [LINE_W-1:0] line_next;
  assign dreq = bus.dcache_pmem_read || bus.dcache_pmem_write;
  assign ireq = bus.icache_pmem_read;
  assign busy = state inside {I_READ, D_READ, D_WRITE};
`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_owner;
  assign grant_d = dreq && (!ireq || last_owner == OWN_I);
`else
  assign grant_d = dreq;
`endif
  line_adapter #(.LINE_BEATS(LINE_BEATS)) u_adapter (
    .clk(clk),
    .reset(reset),
    .active(busy),
    .wr(state == D_WRITE),
    .resp(bus.mem_resp),
    .wdata(bus.dcache_pmem_wdata),
    .burst_i(bus.mem_burst_i),
    .burst_o(bus.mem_burst_o),
    .line_next(line_next),
    .last(last)
  );
  // arbitration FSM with registered memory strobes, address, responses and returned lines
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      bus.mem_read <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_address <= '0;
      bus.icache_pmem_resp <= 1'b0;
      bus.dcache_pmem_resp <= 1'b0;
      bus.icache_pmem_rdata <= '0;
      bus.dcache_pmem_rdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner <= OWN_I;
`endif
    end else
      case (state)
        IDLE:
          if (grant_d) begin
            state <= bus.dcache_pmem_write ? D_WRITE : D_READ;
            bus.mem_write <= bus.dcache_pmem_write;
            bus.mem_read <= !bus.dcache_pmem_write;
            bus.mem_address <= bus.dcache_pmem_address & LINE_MASK;
          end else if (ireq) begin
            state <= I_READ;
            bus.mem_read <= 1'b1;
            bus.mem_address <= bus.icache_pmem_address & LINE_MASK;
          end
        I_READ, D_READ, D_WRITE:
          if (last) begin
            state <= DONE;
            bus.mem_read <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.icache_pmem_resp <= state == I_READ;
            bus.dcache_pmem_resp <= state != I_READ;
            if (state == I_READ) bus.icache_pmem_rdata <= line_next;
            if (state == D_READ) bus.dcache_pmem_rdata <= line_next;
          end
        DONE: begin
          state <= IDLE;
          bus.icache_pmem_resp <= 1'b0;
          bus.dcache_pmem_resp <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
          last_owner <= bus.icache_pmem_resp ? OWN_I : OWN_D;
`endif
        end
        default: state <= IDLE;
      endcase
  // simultaneous dcache read and write is illegal; the write wins
  always_ff @(posedge clk)
    if (!reset && state == IDLE)
      assert (!(bus.dcache_pmem_read && bus.dcache_pmem_write))
      else $warning("mem_arbiter: dcache read and write both asserted, servicing write");
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  mem_arbiter_if bus();
  mem_arbiter #(.LINE_BEATS(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  localparam logic [LINE_W-1:0] L1 = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
  localparam logic [LINE_W-1:0] L2 = {64'hA0A0A0A0A0A0A0A3, 64'hA0A0A0A0A0A0A0A2, 64'hA0A0A0A0A0A0A0A1, 64'hA0A0A0A0A0A0A0A0};
  localparam logic [LINE_W-1:0] L3 = {64'hB3B3B3B3B3B3B3B3, 64'hB2B2B2B2B2B2B2B2, 64'hB1B1B1B1B1B1B1B1, 64'hB0B0B0B0B0B0B0B0};
  localparam logic [LINE_W-1:0] L4 = {64'hD4D4D4D400000004, 64'hD3D3D3D300000003, 64'hD2D2D2D200000002, 64'hD1D1D1D100000001};
  localparam logic [LINE_W-1:0] W1 = {64'hCAFE000000000003, 64'hCAFE000000000002, 64'hCAFE000000000001, 64'hCAFE000000000000};
  localparam logic [LINE_W-1:0] W2 = {64'hBEEF0000000000D3, 64'hBEEF0000000000D2, 64'hBEEF0000000000D1, 64'hBEEF0000000000D0};

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic serve(input string tag, input bit is_wr, input logic [31:0] aexp,
                       input logic [LINE_W-1:0] rd, input logic [LINE_W-1:0] wexp, input bit stall);
    for (int k = 0; k < 4; k++) begin
      if (stall && k == 2)
        for (int s = 0; s < 5; s++) begin
          bus.mem_resp = 1'b0;
          chk({tag, "/stall_addr"}, bus.mem_address, aexp);
          chk({tag, "/stall_rw"}, {bus.mem_read, bus.mem_write}, is_wr ? 2'b01 : 2'b10);
          chk({tag, "/stall_resp"}, {bus.icache_pmem_resp, bus.dcache_pmem_resp}, 2'b00);
          if (is_wr) chk({tag, "/stall_wd"}, bus.mem_burst_o, wexp[64*k +: 64]);
          cyc(1);
        end
      chk({tag, "/addr"}, bus.mem_address, aexp);
      chk({tag, "/rw"}, {bus.mem_read, bus.mem_write}, is_wr ? 2'b01 : 2'b10);
      if (is_wr) chk({tag, "/wd"}, bus.mem_burst_o, wexp[64*k +: 64]);
      bus.mem_resp = 1'b1;
      bus.mem_burst_i = rd[64*k +: 64];
      cyc(1);
    end
    bus.mem_resp = 1'b0;
    bus.mem_burst_i = '0;
    chk({tag, "/done_rw"}, {bus.mem_read, bus.mem_write}, 2'b00);
  endtask

  initial begin
    bus.icache_pmem_read = 1'b0;
    bus.icache_pmem_address = '0;
    bus.dcache_pmem_read = 1'b0;
    bus.dcache_pmem_write = 1'b0;
    bus.dcache_pmem_address = '0;
    bus.dcache_pmem_wdata = '0;
    bus.mem_burst_i = '0;
    bus.mem_resp = 1'b0;
    #1;
    chk("rst_rw", {bus.mem_read, bus.mem_write}, 2'b00);
    chk("rst_addr", bus.mem_address, 32'h0);
    chk("rst_resp", {bus.icache_pmem_resp, bus.dcache_pmem_resp}, 2'b00);
    chk("rst_irdata", bus.icache_pmem_rdata, '0);
    chk("rst_drdata", bus.dcache_pmem_rdata, '0);
    chk("rst_wd", bus.mem_burst_o, '0);
    cyc(1);
    reset = 1'b0;
    cyc(1);
    chk("idle_rw", {bus.mem_read, bus.mem_write}, 2'b00);
    // icache line fill with unaligned address
    bus.icache_pmem_read = 1'b1;
    bus.icache_pmem_address = 32'h0000_0044;
    cyc(1);
    serve("ir1", 1'b0, 32'h0000_0040, L1, '0, 1'b0);
    chk("ir1_resp", {bus.icache_pmem_resp, bus.dcache_pmem_resp}, 2'b10);
    chk("ir1_rdata", bus.icache_pmem_rdata, L1);
    bus.icache_pmem_read = 1'b0;
    cyc(1);
    chk("ir1_resp_drop", {bus.icache_pmem_resp, bus.dcache_pmem_resp}, 2'b00);
    chk("ir1_hold", bus.icache_pmem_rdata, L1);
    // simultaneous requests: dcache write goes first, icache waits
    bus.icache_pmem_read = 1'b1;
    bus.icache_pmem_address = 32'h1000_0004;
    bus.dcache_pmem_write = 1'b1;
    bus.dcache_pmem_address = 32'h8000_0020;
    bus.dcache_pmem_wdata = W1;
    cyc(1);
    serve("dw2", 1'b1, 32'h8000_0020, '0, W1, 1'b0);
    chk("dw2_resp", {bus.icache_pmem_resp, bus.dcache_pmem_resp}, 2'b01);
    bus.dcache_pmem_write = 1'b0;
    cyc(1);
    chk("gap_rw", {bus.mem_read, bus.mem_write}, 2'b00);
    chk("gap_resp", {bus.icache_pmem_resp, bus.dcache_pmem_resp}, 2'b00);
    cyc(1);
    serve("ir2", 1'b0, 32'h1000_0000, L2, '0, 1'b0);
    chk("ir2_resp", {bus.icache_pmem_resp, bus.dcache_pmem_resp}, 2'b10);
    chk("ir2_rdata", bus.icache_pmem_rdata, L2);
    chk("ir2_drdata", bus.dcache_pmem_rdata, '0);
    bus.icache_pmem_read = 1'b0;
    cyc(1);
    // both pending again, dcache re-requests during DONE: policy decides the next grant
    bus.icache_pmem_read = 1'b1;
    bus.icache_pmem_address = 32'h1000_0100;
    bus.dcache_pmem_write = 1'b1;
    bus.dcache_pmem_address = 32'h8000_0040;
    cyc(1);
    serve("dw3", 1'b1, 32'h8000_0040, '0, W1, 1'b0);
    chk("dw3_resp", {bus.icache_pmem_resp, bus.dcache_pmem_resp}, 2'b01);
    bus.dcache_pmem_address = 32'h8000_0060;
    bus.dcache_pmem_wdata = W2;
    cyc(2);
`ifdef ARB_ROUND_ROBIN_EN
    serve("ir3", 1'b0, 32'h1000_0100, L3, '0, 1'b0);
    chk("ir3_resp", {bus.icache_pmem_resp, bus.dcache_pmem_resp}, 2'b10);
    chk("ir3_rdata", bus.icache_pmem_rdata, L3);
    bus.icache_pmem_read = 1'b0;
    cyc(2);
    serve("dw4", 1'b1, 32'h8000_0060, '0, W2, 1'b0);
    chk("dw4_resp", {bus.icache_pmem_resp, bus.dcache_pmem_resp}, 2'b01);
    bus.dcache_pmem_write = 1'b0;
    cyc(1);
`else
    serve("dw4", 1'b1, 32'h8000_0060, '0, W2, 1'b0);
    chk("dw4_resp", {bus.icache_pmem_resp, bus.dcache_pmem_resp}, 2'b01);
    bus.dcache_pmem_write = 1'b0;
    cyc(2);
    serve("ir3", 1'b0, 32'h1000_0100, L3, '0, 1'b0);
    chk("ir3_resp", {bus.icache_pmem_resp, bus.dcache_pmem_resp}, 2'b10);
    chk("ir3_rdata", bus.icache_pmem_rdata, L3);
    bus.icache_pmem_read = 1'b0;
    cyc(1);
`endif
    // dcache write with memory stalling five cycles between beats 1 and 2
    bus.dcache_pmem_write = 1'b1;
    bus.dcache_pmem_address = 32'h0000_123C;
    bus.dcache_pmem_wdata = W1;
    cyc(1);
    serve("dw5", 1'b1, 32'h0000_1220, '0, W1, 1'b1);
    chk("dw5_resp", {bus.icache_pmem_resp, bus.dcache_pmem_resp}, 2'b01);
    bus.dcache_pmem_write = 1'b0;
    cyc(1);
    // reset during beat 2 of a dcache read
    bus.dcache_pmem_read = 1'b1;
    bus.dcache_pmem_address = 32'h2000_0040;
    cyc(1);
    chk("dr6_rw", {bus.mem_read, bus.mem_write}, 2'b10);
    for (int k = 0; k < 2; k++) begin
      bus.mem_resp = 1'b1;
      bus.mem_burst_i = L3[64*k +: 64];
      cyc(1);
    end
    bus.mem_burst_i = L3[191:128];
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_rw", {bus.mem_read, bus.mem_write}, 2'b00);
    chk("mid_rst_addr", bus.mem_address, 32'h0);
    chk("mid_rst_resp", {bus.icache_pmem_resp, bus.dcache_pmem_resp}, 2'b00);
    chk("mid_rst_irdata", bus.icache_pmem_rdata, '0);
    chk("mid_rst_wd", bus.mem_burst_o, '0);
    bus.mem_resp = 1'b0;
    cyc(1);
    chk("rst_hold_resp", {bus.icache_pmem_resp, bus.dcache_pmem_resp}, 2'b00);
    reset = 1'b0;
    cyc(1);
    serve("dr7", 1'b0, 32'h2000_0040, L4, '0, 1'b0);
    chk("dr7_resp", {bus.icache_pmem_resp, bus.dcache_pmem_resp}, 2'b01);
    chk("dr7_rdata", bus.dcache_pmem_rdata, L4);
    bus.dcache_pmem_read = 1'b0;
    cyc(1);
    // read and write together: write is performed, read data untouched
    bus.dcache_pmem_read = 1'b1;
    bus.dcache_pmem_write = 1'b1;
    bus.dcache_pmem_address = 32'h3000_0000;
    bus.dcache_pmem_wdata = W2;
    cyc(1);
    serve("dw8", 1'b1, 32'h3000_0000, L2, W2, 1'b0);
    chk("dw8_resp", {bus.icache_pmem_resp, bus.dcache_pmem_resp}, 2'b01);
    chk("dw8_rdata", bus.dcache_pmem_rdata, L4);
    bus.dcache_pmem_read = 1'b0;
    bus.dcache_pmem_write = 1'b0;
    cyc(1);
    chk("end_rw", {bus.mem_read, bus.mem_write}, 2'b00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
